if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage LA32R pipeline, directly upstream of the decode stage.
- Owns the PC and generates next-PC (sequential or redirect from decode's branch resolution).
- Drives a synchronous instruction SRAM with 1-cycle read latency and presents {pc, inst, valid} to decode with a valid/allow-in handshake.
- Buffers the returned instruction while decode back-pressures, so no fetch is lost or duplicated.

Parameters:
- RESET_PC, 32'h1c000000, address of the first instruction fetched after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0); deassertion is synchronous to clk.
- ds_allow_in  input  1  decode can accept an instruction this cycle.
- br_taken_cancel  input  1  decode resolved a taken branch/jump this cycle (level; may stay high several cycles).
- br_target  input  32  redirect address, valid when br_taken_cancel=1.
- inst_sram_en  output  1  read request to instruction SRAM.
- inst_sram_we  output  4  always 4'b0.
- inst_sram_addr  output  32  read address (= nextpc).
- inst_sram_wdata  output  32  always 32'b0.
- inst_sram_rdata  input  32  read data, valid the cycle after an accepted request.
- fs_to_ds_valid  output  1  fs_pc/fs_inst hold a valid, correct-path instruction for decode.
- fs_pc  output  32  PC of the instruction in IF.
- fs_inst  output  32  instruction word in IF.

Behaviour:
- State: fs_valid, fs_pc (32), inst_buf (32), buf_valid.
- Reset (reset=0, async): fs_valid=0; fs_pc=RESET_PC-4 (32'h1bfffffc for the default); buf_valid=0; inst_buf=0.
- Outputs during reset: inst_sram_en=0, fs_to_ds_valid=0.
- Pre-IF: nextpc = br_taken_cancel ? br_target : fs_pc+4, with 32-bit wrap (no carry out). inst_sram_addr=nextpc.
- fs_ready_go=1.
- fs_allow_in = !fs_valid | (ds_allow_in & fs_ready_go) | br_taken_cancel.
- inst_sram_en = reset & fs_allow_in (a request is issued exactly when IF accepts).
- On an edge with fs_allow_in=1: fs_valid<=1, fs_pc<=nextpc, buf_valid<=0. The instruction arrives on inst_sram_rdata in the following cycle.
- First cycle after reset release: fs_allow_in=1 (fs_valid=0). SRAM fetches RESET_PC; next cycle fs_pc=RESET_PC, fs_valid=1.
- fs_inst = buf_valid ? inst_buf : inst_sram_rdata.
- fs_to_ds_valid = fs_valid & fs_ready_go & !br_taken_cancel. A wrong-path instruction is never offered while the redirect is asserted.
- Back-pressure, when fs_valid & !ds_allow_in & !br_taken_cancel & !buf_valid: inst_buf<=inst_sram_rdata, buf_valid<=1. While buffered, further SRAM output changes are ignored.
- Redirect priority: br_taken_cancel overrides ds_allow_in=0.
  - The current IF instruction is discarded.
  - buf_valid is cleared.
  - fs_pc<=br_target next cycle.
- br_taken_cancel held N cycles: target refetched each cycle. Idempotent: fs_pc=br_target and no instruction passes to decode until it drops.
- Redirect and back-pressure in the same cycle: the redirect wins and nothing is buffered.
- Reset mid-fetch: in-flight SRAM data is ignored because fs_valid=0. Fetch restarts at RESET_PC.
- No exceptions. A misaligned br_target is passed through unchanged.

Test Plan:
- Release reset with ds_allow_in=1 and SRAM holding word n at 32'h1c000000+4n -> inst_sram_addr sequence 1c000000, 1c000004, 1c000008; fs_to_ds_valid rises one cycle after release with fs_pc=1c000000 and fs_inst=word0.
- Stall: ds_allow_in=0 for 3 cycles with fs_pc=1c000008 -> inst_sram_en=0 throughout; fs_inst stays word2 even if rdata is driven to 32'hdeadbeef; after release the next accepted pc is 1c00000c and no instruction is skipped or repeated.
- Branch: br_taken_cancel=1 for 1 cycle with br_target=1c000100 while fs_pc=1c000008 -> fs_to_ds_valid=0 that cycle; inst_sram_addr=1c000100; next cycle fs_pc=1c000100 with the correct word.
- Redirect during stall: ds_allow_in=0, buf_valid=1, br_taken_cancel=1 with target 1c000040 -> buffer dropped; fs_pc=1c000040 next cycle; fs_inst comes from the SRAM.
- Held redirect: br_taken_cancel high 3 cycles with target 1c000080 -> inst_sram_addr=1c000080 each cycle; fs_to_ds_valid stays 0 until the drop, then fs_pc=1c000080 is delivered once.
- Async reset asserted mid-cycle during a stall -> fs_to_ds_valid=0 and inst_sram_en=0 immediately; after release the first fetch address is 1c000000.

Source files
------------

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the 5-stage LA32R pipeline.
//
// Owns the architectural fetch PC, computes the next PC (sequential or a
// redirect coming back from decode's branch resolution), issues reads to a
// synchronous instruction SRAM with one-cycle read latency, and hands
// {pc, inst, valid} to decode through a valid / allow-in handshake.  While
// decode back-pressures, the word returned by the SRAM is captured in a
// one-entry buffer so that later SRAM output changes cannot corrupt it.
//
// Ports
//   clk              : clock, all state updates on the rising edge
//   reset            : asynchronous active-low reset (0 = in reset)
//   ds_allow_in      : decode can accept an instruction this cycle
//   br_taken_cancel  : decode resolved a taken branch/jump (level)
//   br_target        : redirect address, meaningful when br_taken_cancel=1
//   inst_sram_en     : read request to the instruction SRAM
//   inst_sram_we     : byte write enables, tied to zero
//   inst_sram_addr   : read address (the next PC)
//   inst_sram_wdata  : write data, tied to zero
//   inst_sram_rdata  : read data, valid the cycle after an accepted request
//   fs_to_ds_valid   : fs_pc / fs_inst hold a valid correct-path instruction
//   fs_pc            : PC of the instruction currently in IF
//   fs_inst          : instruction word currently in IF
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allow_in,
  input  logic        br_taken_cancel,
  input  logic [31:0] br_target,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst
);

  // The PC register resets one word below RESET_PC so that the very first
  // sequential next-PC computation lands exactly on RESET_PC.
  localparam logic [31:0] PC_RESET_VAL = RESET_PC - 32'd4;

  // State registers and their next-state values.
  logic        fs_valid_q,  fs_valid_d;
  logic [31:0] fs_pc_q,     fs_pc_d;
  logic [31:0] inst_buf_q,  inst_buf_d;
  logic        buf_valid_q, buf_valid_d;

  // Combinational helpers.
  logic        fs_ready_go_s;
  logic        fs_allow_in_s;
  logic [31:0] nextpc_s;
  logic        capture_s;

  // Handshake and pre-IF next-PC selection.
  always_comb begin
    fs_ready_go_s = 1'b1;
    // A taken redirect always makes room: the instruction held in IF is on
    // the wrong path and is simply discarded.
    fs_allow_in_s = !fs_valid_q
                  | (ds_allow_in & fs_ready_go_s)
                  | br_taken_cancel;
    if (br_taken_cancel) begin
      nextpc_s = br_target;
    end else begin
      nextpc_s = fs_pc_q + 32'd4;
    end
    // Capture the SRAM word exactly once, on the first stalled cycle; later
    // cycles must keep the buffered copy because the SRAM output is free to
    // change while no request is outstanding.
    capture_s = fs_valid_q & !ds_allow_in & !br_taken_cancel & !buf_valid_q;
  end

  // Next-state logic for the IF registers.
  always_comb begin
    fs_valid_d  = fs_valid_q;
    fs_pc_d     = fs_pc_q;
    inst_buf_d  = inst_buf_q;
    buf_valid_d = buf_valid_q;
    if (fs_allow_in_s) begin
      // A new request is issued this cycle; its data returns next cycle
      // straight from the SRAM, so any buffered word becomes stale.
      fs_valid_d  = 1'b1;
      fs_pc_d     = nextpc_s;
      buf_valid_d = 1'b0;
    end else if (capture_s) begin
      inst_buf_d  = inst_sram_rdata;
      buf_valid_d = 1'b1;
    end else begin
      fs_valid_d  = fs_valid_q;
      fs_pc_d     = fs_pc_q;
      inst_buf_d  = inst_buf_q;
      buf_valid_d = buf_valid_q;
    end
  end

  // IF state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fs_valid_q  <= 1'b0;
      fs_pc_q     <= PC_RESET_VAL;
      inst_buf_q  <= 32'h0000_0000;
      buf_valid_q <= 1'b0;
    end else begin
      fs_valid_q  <= fs_valid_d;
      fs_pc_q     <= fs_pc_d;
      inst_buf_q  <= inst_buf_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  // SRAM request and decode-facing outputs.
  always_comb begin
    // Gating with reset keeps the SRAM idle while reset is held, even though
    // fs_allow_in is high then (fs_valid is 0).
    inst_sram_en    = reset & fs_allow_in_s;
    inst_sram_we    = 4'b0000;
    inst_sram_addr  = nextpc_s;
    inst_sram_wdata = 32'h0000_0000;
    // Never offer the instruction in IF while a redirect is asserted: it is
    // wrong-path by definition.
    fs_to_ds_valid  = fs_valid_q & fs_ready_go_s & !br_taken_cancel;
    fs_pc           = fs_pc_q;
    if (buf_valid_q) begin
      fs_inst = inst_buf_q;
    end else begin
      fs_inst = inst_sram_rdata;
    end
  end

endmodule
